// File: rtl/k005297_dmaseq.sv
// k005297_dmaseq: bubble<->RAM word DMA sequencer; optional 16-word tenure limit via K005297_DMASEQ_BURST_LIMIT_EN.
// Latency: one 4 MHz enable per state step, 8 enables per word; stalls in WAIT_ACT/RELEASE until the frontend grants/releases the bus.
module k005297_dmaseq (
    input  logic        i_MCLK,
    input  logic        i_SYS_RST_n,
    input  logic        i_CLK4M_PCEN_n,
    input  logic [7:0]  i_ROT8,
    input  logic        i_XFER_REQ,
    input  logic        i_XFER_DIR,
    input  logic [22:0] i_BASE_ADDR,
    input  logic [7:0]  i_WORD_CNT,
    input  logic        i_ABORT,
    input  logic        i_DMA_ACT,
    input  logic        i_ALD_EN,
    output logic        o_BR_START_n,
    output logic        o_DMA_END,
    output logic [22:0] o_ADDR,
    output logic        o_R_nW,
    output logic        o_AS_n,
    output logic        o_DS_n,
    output logic        o_WORD_STB,
    output logic        o_BUSY,
    output logic        o_DONE
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_ACT, S_XFER, S_END, S_RELEASE
    } state_t;

    state_t      state_q;
    logic [22:0] addr_q, addr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        dir_q, br_start_n_q, dma_end_q, strb_n_q, word_stb_q, done_q;
    logic        end_cnt_q, cyc_q, abort_q, cont_q;
    logic        en, bus_ok, last_word, limit_hit;
    logic        unused_rot;

    assign en        = ~i_CLK4M_PCEN_n;
    assign bus_ok    = i_DMA_ACT & i_ALD_EN;
    assign addr_d    = addr_q + 23'd1;
    assign cnt_d     = cnt_q - 9'd1;
    assign last_word = (cnt_q == 9'd1);
    // Strobe timing keys off phases 1/5/6 only; the rest of the rotor is informational.
    assign unused_rot = ^{i_ROT8[7], i_ROT8[4:2], i_ROT8[0]};

`ifdef K005297_DMASEQ_BURST_LIMIT_EN
    logic [3:0] burst_q;
    assign limit_hit = (burst_q == 4'd15);
`else
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
        if (!i_SYS_RST_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b1;
            br_start_n_q <= 1'b1;
            dma_end_q    <= 1'b0;
            strb_n_q     <= 1'b1;
            word_stb_q   <= 1'b0;
            done_q       <= 1'b0;
            end_cnt_q    <= 1'b0;
            cyc_q        <= 1'b0;
            abort_q      <= 1'b0;
            cont_q       <= 1'b0;
`ifdef K005297_DMASEQ_BURST_LIMIT_EN
            burst_q      <= '0;
`endif
        end else if (en) begin
            word_stb_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: if (i_XFER_REQ) begin
                    addr_q  <= i_BASE_ADDR;
                    cnt_q   <= {(i_WORD_CNT == 8'd0), i_WORD_CNT};
                    dir_q   <= i_XFER_DIR;
                    cont_q  <= 1'b0;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (i_ABORT) begin
                        cont_q    <= 1'b0;
                        dma_end_q <= 1'b1;
                        state_q   <= S_END;
                    end else begin
                        br_start_n_q <= 1'b0;
                        state_q      <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    br_start_n_q <= 1'b1;
                    if (i_ABORT) begin
                        cont_q    <= 1'b0;
                        dma_end_q <= 1'b1;
                        state_q   <= S_END;
                    end else if (i_DMA_ACT) begin
`ifdef K005297_DMASEQ_BURST_LIMIT_EN
                        burst_q <= '0;
`endif
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    // A started word always runs to completion; abort only stops the next one.
                    if (cyc_q) begin
                        if (i_ABORT) abort_q <= 1'b1;
                        if (i_ROT8[5]) strb_n_q <= 1'b1;
                        if (i_ROT8[6]) begin
                            cyc_q      <= 1'b0;
                            word_stb_q <= 1'b1;
                            addr_q     <= addr_d;
                            cnt_q      <= cnt_d;
`ifdef K005297_DMASEQ_BURST_LIMIT_EN
                            burst_q    <= burst_q + 4'd1;
`endif
                            if (last_word || abort_q || i_ABORT || limit_hit) begin
                                cont_q    <= limit_hit && !last_word && !abort_q && !i_ABORT;
                                abort_q   <= 1'b0;
                                dma_end_q <= 1'b1;
                                state_q   <= S_END;
                            end
                        end
                    end else if (i_ABORT) begin
                        cont_q    <= 1'b0;
                        dma_end_q <= 1'b1;
                        state_q   <= S_END;
                    end else if (i_ROT8[1] && bus_ok) begin
                        cyc_q    <= 1'b1;
                        strb_n_q <= 1'b0;
                    end
                end
                S_END: begin
                    if (end_cnt_q) begin
                        end_cnt_q <= 1'b0;
                        dma_end_q <= 1'b0;
                        state_q   <= S_RELEASE;
                    end else begin
                        end_cnt_q <= 1'b1;
                    end
                end
                S_RELEASE: if (!i_DMA_ACT) begin
                    if (cont_q) begin
                        cont_q  <= 1'b0;
                        state_q <= S_REQ;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_BR_START_n = br_start_n_q;
    assign o_DMA_END    = dma_end_q;
    assign o_ADDR       = addr_q;
    assign o_R_nW       = dir_q;
    assign o_AS_n       = strb_n_q | ~bus_ok;
    assign o_DS_n       = strb_n_q | ~bus_ok;
    assign o_WORD_STB   = word_stb_q;
    assign o_BUSY       = (state_q != S_IDLE);
    assign o_DONE       = done_q;

endmodule

// File: doc/k005297_dmaseq.md
K005297_DMASEQ -- requirements
Module: k005297_dmaseq

Interface
REQ-001 SHALL have i_MCLK  in  1  master clock; all state changes on posedge.
REQ-002 SHALL have i_SYS_RST_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active-low; state advances only when low.
REQ-004 SHALL have i_ROT8  in  8  one-hot bus-cycle phase, rotating per 4 MHz enable.
REQ-005 SHALL have i_XFER_REQ  in  1  start pulse from the bubble-side controller.
REQ-006 SHALL have i_XFER_DIR  in  1  0 = bubble to RAM (write), 1 = RAM to bubble (read).
REQ-007 SHALL have i_BASE_ADDR  in  23  68000 word start address, sampled at start.
REQ-008 SHALL have i_WORD_CNT  in  8  word count, sampled at start; 0 means 256.
REQ-009 SHALL have i_ABORT  in  1  level; terminates the transfer.
REQ-010 SHALL have i_DMA_ACT and i_ALD_EN  in  1 each  bus tenure active and address drive enable from the DMA frontend.
REQ-011 SHALL have o_BR_START_n  out  1  active-low bus-request start pulse to the frontend.
REQ-012 SHALL have o_DMA_END  out  1  tenure end; the frontend acts on its rising edge.
REQ-013 SHALL have o_ADDR  out  23  current word address.
REQ-014 SHALL have o_R_nW, o_AS_n, o_DS_n  out  1 each  68000 bus strobes.
REQ-015 SHALL have o_WORD_STB  out  1  one-enable pulse per completed word.
REQ-016 SHALL have o_BUSY and o_DONE  out  1 each  block-level status; o_DONE is a one-enable pulse.

Function
REQ-017 SHALL implement the states IDLE, REQ, WAIT_ACT, XFER, END and RELEASE, evaluated only on enabled cycles.
REQ-018 SHALL, in IDLE on i_XFER_REQ=1, load the address and count registers and enter REQ; i_XFER_REQ SHALL be ignored in every other state.
REQ-019 SHALL, in REQ, drive o_BR_START_n low for exactly one enable cycle, then enter WAIT_ACT.
REQ-020 SHALL, in WAIT_ACT, enter XFER on the first enable with i_DMA_ACT=1.
REQ-021 SHALL, in XFER with i_ALD_EN=1, drive o_AS_n and o_DS_n low from ROT8[2] through ROT8[5] and high from ROT8[6]; o_R_nW SHALL equal i_XFER_DIR (latched at start) for the whole tenure.
REQ-022 SHALL, at ROT8[7] of each strobed cycle, pulse o_WORD_STB, increment o_ADDR (0x7FFFFF wraps to 0x000000) and decrement the count.
REQ-023 SHALL, when the count reaches 0 at ROT8[7], enter END.
REQ-024 SHALL, in END, hold o_DMA_END=1 for 2 enable cycles, then enter RELEASE.
REQ-025 SHALL, in RELEASE, wait for i_DMA_ACT=0, then pulse o_DONE and enter IDLE.
REQ-026 SHALL, when i_ABORT=1 in XFER, complete the bus cycle in progress (strobes high at ROT8[6]) and then enter END without decrementing the count further.
REQ-027 SHALL, when i_ABORT=1 in REQ or WAIT_ACT, enter END directly.
REQ-028 SHALL drive o_BUSY=1 in every state except IDLE.
REQ-029 SHALL force o_AS_n and o_DS_n high whenever i_DMA_ACT=0 or i_ALD_EN=0.

Reset
REQ-030 SHALL, on i_SYS_RST_n=0, immediately enter IDLE, including mid-transfer.
REQ-031 SHALL, on i_SYS_RST_n=0, drive o_BR_START_n, o_AS_n and o_DS_n to 1, o_R_nW to 1, and every other output and register to 0.

Configuration
REQ-032 SHALL, when K005297_DMASEQ_BURST_LIMIT_EN is defined, limit each tenure to 16 words: after the 16th word with count ≠ 0, enter END, then RELEASE, then REQ (no o_DONE pulse), keeping the address and count.
REQ-033 SHALL, when K005297_DMASEQ_BURST_LIMIT_EN is undefined, transfer the whole count in one tenure.

Verification
REQ-034 SHALL cover: base 0x001000, count 4, dir 0 -> one o_BR_START_n pulse, 4 o_WORD_STB pulses, final o_ADDR 0x001004, o_R_nW=0, o_DMA_END high for 2 enables, one o_DONE.
REQ-035 SHALL cover: count 0 -> 256 words transferred, final address equal to base + 0x100.
REQ-036 SHALL cover: base 0x7FFFFE, count 3 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000.
REQ-037 SHALL cover: i_ABORT asserted at ROT8[3] of word 2 -> that cycle completes, 2 strobes total, o_DMA_END asserted, o_DONE pulsed.
REQ-038 SHALL cover: reset asserted mid-XFER -> all outputs at reset values asynchronously, and a new request after reset runs normally.
REQ-039 SHALL cover: with K005297_DMASEQ_BURST_LIMIT_EN defined and count 40 -> 3 tenures of 16/16/8 words, 3 o_BR_START_n pulses and 1 o_DONE.
